// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, control-group bit positions, bubble encodings.
// Combinational helpers only; no latency, no flow control.
package pipeline_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 5;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_BITS = 8;

  // mem control group: [2]=Branch, [1]=MemRead, [0]=MemWrite
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  // wb control group: [1]=RegWrite, [0]=MemtoReg
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  localparam logic [2:0] MEM_CTRL_BUBBLE = 3'b000;
  localparam logic [1:0] WB_CTRL_BUBBLE  = 2'b00;

  function automatic logic word_aligned(input logic [1:0] byte_lsb);
    return byte_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: asynchronous read, write on rising clk edge, contents not reset.
// Read is zero-latency; write commits at the edge where i_we is high; no backpressure.
module data_memory
  import pipeline_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int depth     = MEM_DEPTH,
  parameter int addr_bits = ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [addr_bits-1:0] i_addr,
  input  logic [word_size-1:0] i_wdata,
  output logic [word_size-1:0] o_rdata
);

  logic [word_size-1:0] r_mem [depth];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read sees the pre-write word during the write cycle.
  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, branch resolve, data memory access, MEM/WB register.
// exmem_* valid one edge after inputs, memwb_* two; stall freezes both registers and blocks stores, flush bubbles EX/MEM.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int reg_size  = REG_SIZE,
  parameter int mem_depth = MEM_DEPTH,
  parameter int addr_bits = ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [word_size-1:0] alu_result,
  input  logic                 zero,
  input  logic [word_size-1:0] WriteData,
  input  logic [word_size-1:0] AddResult,
  input  logic [reg_size-1:0]  destination_reg,
  input  logic [2:0]           mem_control_signals,
  input  logic [1:0]           wb_control_signals,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 pc_src,
  output logic [word_size-1:0] branch_target,
  output logic                 exmem_reg_write,
  output logic [reg_size-1:0]  exmem_rd,
  output logic [word_size-1:0] exmem_alu_result,
  output logic                 misaligned,
  output logic [word_size-1:0] memwb_read_data,
  output logic [word_size-1:0] memwb_alu_result,
  output logic [reg_size-1:0]  memwb_rd,
  output logic [1:0]           memwb_wb_ctrl
);

  typedef struct packed {
    logic [word_size-1:0] alu_result;
    logic                 zero;
    logic [word_size-1:0] write_data;
    logic [word_size-1:0] add_result;
    logic [reg_size-1:0]  rd;
    logic [2:0]           mem_ctrl;
    logic [1:0]           wb_ctrl;
  } exmem_t;

  typedef struct packed {
    logic [word_size-1:0] read_data;
    logic [word_size-1:0] alu_result;
    logic [reg_size-1:0]  rd;
    logic [1:0]           wb_ctrl;
  } memwb_t;

  exmem_t r_exmem;
  memwb_t r_memwb;

  logic [addr_bits-1:0] w_idx;
  logic                 w_mem_read;
  logic                 w_mem_write;
  logic                 w_aligned;
  logic                 w_we;
  logic [word_size-1:0] w_mem_rdata;
  logic [word_size-1:0] w_load_data;

  // Flush only needs to kill side effects, so datapath fields are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmem <= '0;
    end else if (flush) begin
      r_exmem.mem_ctrl <= MEM_CTRL_BUBBLE;
      r_exmem.wb_ctrl  <= WB_CTRL_BUBBLE;
    end else if (!stall) begin
      r_exmem <= '{alu_result: alu_result,
                   zero:       zero,
                   write_data: WriteData,
                   add_result: AddResult,
                   rd:         destination_reg,
                   mem_ctrl:   mem_control_signals,
                   wb_ctrl:    wb_control_signals};
    end
  end

  assign w_mem_read  = r_exmem.mem_ctrl[MEMREAD];
  assign w_mem_write = r_exmem.mem_ctrl[MEMWRITE];
  assign w_idx       = r_exmem.alu_result[addr_bits+1:2];
  assign w_aligned   = word_aligned(r_exmem.alu_result[1:0]);
  assign w_we        = w_mem_write & w_aligned & ~stall;
  assign w_load_data = w_mem_read ? w_mem_rdata : '0;

  data_memory #(
    .word_size (word_size),
    .depth     (mem_depth),
    .addr_bits (addr_bits)
  ) u_data_memory (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (r_exmem.write_data),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memwb <= '0;
    end else if (!stall) begin
      r_memwb <= '{read_data:  w_load_data,
                   alu_result: r_exmem.alu_result,
                   rd:         r_exmem.rd,
                   wb_ctrl:    r_exmem.wb_ctrl};
    end
  end

  assign pc_src           = r_exmem.mem_ctrl[BRANCH] & r_exmem.zero;
  assign branch_target    = r_exmem.add_result;
  assign exmem_reg_write  = r_exmem.wb_ctrl[REGWRITE];
  assign exmem_rd         = r_exmem.rd;
  assign exmem_alu_result = r_exmem.alu_result;
  assign misaligned       = (w_mem_read | w_mem_write) & ~w_aligned;

  assign memwb_read_data  = r_memwb.read_data;
  assign memwb_alu_result = r_memwb.alu_result;
  assign memwb_rd         = r_memwb.rd;
  assign memwb_wb_ctrl    = r_memwb.wb_ctrl;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage against a transaction-level model.
module tb_mem_stage;

  localparam int BR = 2;
  localparam int MR = 1;
  localparam int MW = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_result = '0;
  logic        zero = 1'b0;
  logic [31:0] WriteData = '0;
  logic [31:0] AddResult = '0;
  logic [4:0]  destination_reg = '0;
  logic [2:0]  mem_control_signals = '0;
  logic [1:0]  wb_control_signals = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu_result;
  logic        misaligned;
  logic [31:0] memwb_read_data;
  logic [31:0] memwb_alu_result;
  logic [4:0]  memwb_rd;
  logic [1:0]  memwb_wb_ctrl;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alu_result          (alu_result),
    .zero                (zero),
    .WriteData           (WriteData),
    .AddResult           (AddResult),
    .destination_reg     (destination_reg),
    .mem_control_signals (mem_control_signals),
    .wb_control_signals  (wb_control_signals),
    .stall               (stall),
    .flush               (flush),
    .pc_src              (pc_src),
    .branch_target       (branch_target),
    .exmem_reg_write     (exmem_reg_write),
    .exmem_rd            (exmem_rd),
    .exmem_alu_result    (exmem_alu_result),
    .misaligned          (misaligned),
    .memwb_read_data     (memwb_read_data),
    .memwb_alu_result    (memwb_alu_result),
    .memwb_rd            (memwb_rd),
    .memwb_wb_ctrl       (memwb_wb_ctrl)
  );

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wdata;
    logic [31:0] target;
    logic [4:0]  rd;
    logic [2:0]  mc;
    logic [1:0]  wc;
  } instr_t;

  typedef struct {
    logic        pc_src;
    logic [31:0] bt;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu;
    logic        mis;
    logic [31:0] rdata;
    logic [31:0] wb_alu;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_ctrl;
    bit          ex_valid;
    bit          wb_valid;
    bit          rd_known;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: instruction sitting in MEM, result sitting in WB, architectural memory.
  instr_t      m_ex;
  bit          m_ex_valid;
  logic [31:0] m_wb_rdata;
  logic [31:0] m_wb_alu;
  logic [4:0]  m_wb_rd;
  logic [1:0]  m_wb_ctrl;
  bit          m_wb_valid;
  bit          m_wb_known;
  logic [31:0] m_mem [256];
  bit          m_known [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    total++;
    if (act !== exv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exv, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc_src"},           32'(pc_src),           32'h0);
    chk({tag, ".branch_target"},    branch_target,         32'h0);
    chk({tag, ".exmem_reg_write"},  32'(exmem_reg_write),  32'h0);
    chk({tag, ".exmem_rd"},         32'(exmem_rd),         32'h0);
    chk({tag, ".exmem_alu_result"}, exmem_alu_result,      32'h0);
    chk({tag, ".misaligned"},       32'(misaligned),       32'h0);
    chk({tag, ".memwb_read_data"},  memwb_read_data,       32'h0);
    chk({tag, ".memwb_alu_result"}, memwb_alu_result,      32'h0);
    chk({tag, ".memwb_rd"},         32'(memwb_rd),         32'h0);
    chk({tag, ".memwb_wb_ctrl"},    32'(memwb_wb_ctrl),    32'h0);
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic z, input logic [31:0] wd,
                                input logic [31:0] tgt, input logic [4:0] rd,
                                input logic [2:0] mc, input logic [1:0] wc);
    instr_t r;
    r.alu = alu; r.zero = z; r.wdata = wd; r.target = tgt; r.rd = rd; r.mc = mc; r.wc = wc;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    logic [31:0] a;
    a = $urandom;
    a[9:2] = 8'($urandom_range(0, 15));
    a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return mk(a, 1'($urandom), $urandom, $urandom, 5'($urandom), 3'($urandom), 2'($urandom));
  endfunction

  task automatic model_reset();
    m_ex = mk(32'h0, 1'b0, 32'h0, 32'h0, 5'h0, 3'b000, 2'b00);
    m_ex_valid = 1;
    m_wb_rdata = '0; m_wb_alu = '0; m_wb_rd = '0; m_wb_ctrl = '0;
    m_wb_valid = 1; m_wb_known = 1;
  endtask

  // One clock edge of the stage, expressed as: read/commit the MEM instruction, retire it to WB, accept the next.
  task automatic model_edge(input instr_t nx, input bit st, input bit fl);
    int          idx;
    bit          aligned;
    logic [31:0] rd_val;
    bit          known;
    idx     = int'((m_ex.alu / 4) % 256);
    aligned = (m_ex.alu % 4) == 0;
    rd_val  = 32'h0;
    known   = 1;
    if (m_ex.mc[MR]) begin
      rd_val = m_mem[idx];
      known  = m_known[idx];
    end
    if (!st) begin
      m_wb_rdata = rd_val; m_wb_known = known;
      m_wb_alu = m_ex.alu; m_wb_rd = m_ex.rd; m_wb_ctrl = m_ex.wc; m_wb_valid = m_ex_valid;
      if (m_ex.mc[MW] && aligned) begin
        m_mem[idx]   = m_ex.wdata;
        m_known[idx] = 1;
      end
    end
    if (fl) begin
      m_ex.mc = 3'b000; m_ex.wc = 2'b00; m_ex_valid = 0;
    end else if (!st) begin
      m_ex = nx; m_ex_valid = 1;
    end
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.pc_src   = m_ex.mc[BR] & m_ex.zero;
    e.bt       = m_ex.target;
    e.ex_rw    = m_ex.wc[1];
    e.ex_rd    = m_ex.rd;
    e.ex_alu   = m_ex.alu;
    e.mis      = (m_ex.mc[MR] | m_ex.mc[MW]) && (m_ex.alu % 4 != 0);
    e.rdata    = m_wb_rdata;
    e.wb_alu   = m_wb_alu;
    e.wb_rd    = m_wb_rd;
    e.wb_ctrl  = m_wb_ctrl;
    e.ex_valid = m_ex_valid;
    e.wb_valid = m_wb_valid;
    e.rd_known = m_wb_known;
    return e;
  endfunction

  task automatic drive(input instr_t ins, input bit st, input bit fl);
    @(negedge clk);
    #1;
    alu_result = ins.alu; zero = ins.zero; WriteData = ins.wdata; AddResult = ins.target;
    destination_reg = ins.rd; mem_control_signals = ins.mc; wb_control_signals = ins.wc;
    stall = st; flush = fl;
    model_edge(ins, st, fl);
    exp_q.push_back(make_exp());
  endtask

  // Monitor: every negedge after an edge with pending expectation, compare the stage outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_src",          32'(pc_src),          32'(e.pc_src));
        chk("exmem_reg_write", 32'(exmem_reg_write), 32'(e.ex_rw));
        chk("misaligned",      32'(misaligned),      32'(e.mis));
        chk("memwb_wb_ctrl",   32'(memwb_wb_ctrl),   32'(e.wb_ctrl));
        if (e.ex_valid) begin
          chk("branch_target",    branch_target,      e.bt);
          chk("exmem_rd",         32'(exmem_rd),      32'(e.ex_rd));
          chk("exmem_alu_result", exmem_alu_result,   e.ex_alu);
        end
        if (e.rd_known) chk("memwb_read_data", memwb_read_data, e.rdata);
        if (e.wb_valid) begin
          chk("memwb_alu_result", memwb_alu_result, e.wb_alu);
          chk("memwb_rd",         32'(memwb_rd),    32'(e.wb_rd));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  instr_t nop;

  initial begin
    nop = mk(32'h0, 1'b0, 32'h0, 32'h0, 5'h0, 3'b000, 2'b00);
    for (int i = 0; i < 256; i++) m_known[i] = 0;
    model_reset();

    // Reset held with random inputs toggling, then released mid-cycle.
    repeat (3) begin
      @(negedge clk);
      alu_result = $urandom; zero = 1'($urandom); WriteData = $urandom; AddResult = $urandom;
      destination_reg = 5'($urandom); mem_control_signals = 3'($urandom);
      wb_control_signals = 2'($urandom);
    end
    @(negedge clk);
    chk_all_zero("rst_hold");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk_all_zero("rst_release");

    // Fill every word with a known value; upper address bits are random to exercise wrap.
    for (int i = 0; i < 256; i++)
      drive(mk((32'(i) * 4) | ($urandom & 32'hFFFF_FC00), 1'b0, $urandom, $urandom,
               5'($urandom), 3'b001, 2'b00), 0, 0);

    // Store then back-to-back load of the same word.
    drive(mk(32'h10, 1'b0, 32'hDEADBEEF, 32'h0, 5'h03, 3'b001, 2'b00), 0, 0);
    drive(mk(32'h10, 1'b0, 32'h0, 32'h0, 5'h09, 3'b010, 2'b11), 0, 0);
    drive(nop, 0, 0);
    drive(nop, 0, 0);

    // Branch taken / not taken.
    drive(mk(32'h0, 1'b1, 32'h0, 32'h21, 5'h0, 3'b100, 2'b00), 0, 0);
    drive(mk(32'h0, 1'b0, 32'h0, 32'h21, 5'h0, 3'b100, 2'b00), 0, 0);

    // R-type passthrough.
    drive(mk(32'd12, 1'b0, 32'h0, 32'h0, 5'h14, 3'b000, 2'b10), 0, 0);
    drive(nop, 0, 0);

    // Misaligned store suppressed, then load word 0x10.
    drive(mk(32'h13, 1'b0, 32'h1234, 32'h0, 5'h0, 3'b001, 2'b00), 0, 0);
    drive(mk(32'h10, 1'b0, 32'h0, 32'h0, 5'h05, 3'b010, 2'b11), 0, 0);
    drive(mk(32'h11, 1'b0, 32'h0, 32'h0, 5'h06, 3'b010, 2'b11), 0, 0);
    drive(nop, 0, 0);

    // Store held by a 3-cycle stall, then a load of the same word.
    drive(mk(32'h20, 1'b0, 32'hCAFEF00D, 32'h0, 5'h0, 3'b001, 2'b00), 0, 0);
    repeat (3) drive(rand_instr(), 1, 0);
    drive(mk(32'h20, 1'b0, 32'h0, 32'h0, 5'h0A, 3'b010, 2'b11), 0, 0);
    drive(nop, 0, 0);
    drive(nop, 0, 0);

    // Read and write together return the pre-write word.
    drive(mk(32'h30, 1'b0, 32'h5555AAAA, 32'h0, 5'h0B, 3'b011, 2'b11), 0, 0);
    drive(mk(32'h30, 1'b0, 32'h0, 32'h0, 5'h0C, 3'b010, 2'b11), 0, 0);
    drive(nop, 0, 0);
    drive(nop, 0, 0);

    // Flush together with stall: EX/MEM bubbled, MEM/WB held.
    drive(mk(32'h40, 1'b0, 32'h0, 32'h0, 5'h0D, 3'b010, 2'b11), 0, 0);
    drive(mk(32'h44, 1'b1, 32'h77, 32'h0, 5'h0E, 3'b101, 2'b11), 0, 0);
    drive(rand_instr(), 1, 1);
    drive(nop, 0, 0);
    drive(nop, 0, 0);

    // Randomized traffic with stalls and flushes.
    for (int n = 0; n < 600; n++)
      drive(rand_instr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    drive(nop, 0, 0);
    drive(nop, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    // Asynchronous reset assertion mid-cycle clears outputs immediately.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
